// File: rtl/data_bus_ctrl.sv
// Decoded CPU data bus: wait-stated byte-enabled RAM, memory-mapped output
// registers and a read-only free-running cycle counter behind a ready handshake.
module data_bus_ctrl #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned RAM_DEPTH   = 256,
    parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
    parameter logic [31:0] IO_BASE     = 32'h8000_0000,
    parameter int unsigned NUM_IO      = 4,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic                     we,
    input  logic [31:0]              addr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/8-1:0]      be,
    output logic [DATA_W-1:0]        rdata,
    output logic                     ready,
    output logic                     err,
    output logic [NUM_IO*DATA_W-1:0] io_out,
    output logic [31:0]              cyc_cnt
);

    localparam int unsigned       BE_W       = DATA_W / 8;
    localparam int unsigned       RAM_AW     = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int unsigned       IO_IW      = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
    localparam logic [31:0]       RAM_SPAN   = 32'(4 * RAM_DEPTH);
    localparam logic [31:0]       IO_SPAN    = 32'(4 * NUM_IO);
    localparam logic [31:0]       CNT_ADDR   = IO_BASE + 32'h100;
    localparam logic [3:0]        WAIT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [DATA_W-1:0] FAULT_DATA = DATA_W'(32'hDEAD_BEEF);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {K_RAM, K_IO, K_CNT, K_NONE} kind_t;

    // Offsets wrap below a region base, so a single unsigned compare bounds each region.
    function automatic kind_t decode(input logic [31:0] a);
        kind_t k;
        if (a[1:0] != 2'b00) begin
            k = K_NONE;
        end else if ((a - RAM_BASE) < RAM_SPAN) begin
            k = K_RAM;
        end else if ((a - IO_BASE) < IO_SPAN) begin
            k = K_IO;
        end else if (a == CNT_ADDR) begin
            k = K_CNT;
        end else begin
            k = K_NONE;
        end
        return k;
    endfunction

    state_t              state_q, state_d;
    logic [3:0]          wait_q, wait_d;
    logic                we_q, we_d;
    logic [31:0]         addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [31:0]         cyc_cnt_q, cyc_cnt_d;
    logic [DATA_W-1:0]   io_q [NUM_IO];
    logic [DATA_W-1:0]   io_d [NUM_IO];
    logic [DATA_W-1:0]   ram_q [RAM_DEPTH];

    logic                acc_we;
    logic [31:0]         acc_addr;
    kind_t               acc_kind;
    logic                acc_fault;
    logic [RAM_AW-1:0]   ram_idx;
    logic [IO_IW-1:0]    io_idx;
    logic                enter_resp;
    logic                commit;

    // In IDLE the request is decoded straight off the port; afterwards off the latched copy.
    always_comb begin
        acc_we    = (state_q == IDLE) ? we : we_q;
        acc_addr  = (state_q == IDLE) ? addr : addr_q;
        acc_kind  = decode(acc_addr);
        acc_fault = (acc_kind == K_NONE) || ((acc_kind == K_CNT) && acc_we);
        ram_idx   = RAM_AW'((acc_addr - RAM_BASE) >> 2);
        io_idx    = IO_IW'((acc_addr - IO_BASE) >> 2);
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if ((acc_kind == K_RAM) && (WAIT_CYCLES > 0)) begin
                        state_d = WAIT;
                        wait_d  = WAIT_LOAD;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rdata_d    = '0;
        err_d      = 1'b0;
        cyc_cnt_d  = cyc_cnt_q + 32'd1;
        io_d       = io_q;
        enter_resp = (state_d == RESP) && (state_q != RESP);
        commit     = (state_q == RESP) && we_q && !acc_fault;

        if ((state_q == IDLE) && req) begin
            we_d    = we;
            addr_d  = addr;
            wdata_d = wdata;
            be_d    = be;
        end

        // Read data is captured once, on the edge that enters RESP, and held for that cycle only.
        if (enter_resp) begin
            if (acc_fault) begin
                rdata_d = FAULT_DATA;
                err_d   = 1'b1;
            end else if (!acc_we) begin
                case (acc_kind)
                    K_RAM:   rdata_d = ram_q[ram_idx];
                    K_IO:    rdata_d = io_q[io_idx];
                    K_CNT:   rdata_d = DATA_W'(cyc_cnt_q);
                    default: rdata_d = '0;
                endcase
            end
        end

        if (commit && (acc_kind == K_IO)) begin
            for (int k = 0; k < BE_W; k++) begin
                if (be_q[k]) begin
                    io_d[io_idx][8*k +: 8] = wdata_q[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cyc_cnt_q <= '0;
            for (int i = 0; i < NUM_IO; i++) begin
                io_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            cyc_cnt_q <= cyc_cnt_d;
            io_q      <= io_d;
        end
    end

    // RAM is deliberately not reset; an aborted access never reaches RESP so never writes.
    always_ff @(posedge clk) begin
        if (commit && (acc_kind == K_RAM)) begin
            for (int k = 0; k < BE_W; k++) begin
                if (be_q[k]) begin
                    ram_q[ram_idx][8*k +: 8] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_IO; g++) begin : g_io_pack
        assign io_out[g*DATA_W +: DATA_W] = io_q[g];
    end

    assign rdata   = rdata_q;
    assign ready   = (state_q == RESP);
    assign err     = err_q;
    assign cyc_cnt = cyc_cnt_q;

endmodule

// File: doc/data_bus_ctrl.md
Name: data_bus_ctrl

Overview:
Parametrised data-side memory subsystem for the 32-bit CPU. It replaces the bare single-cycle data memory with a decoded data bus. The bus contains a word-addressed RAM with configurable wait states and byte enables, a bank of memory-mapped output registers, and a read-only free-running cycle counter. The CPU data port connects directly to it and stalls on the ready handshake; it sits beside instruction memory in the top level.

Parameters:
DATA_W, 32, data bus width in bits (multiple of 8)
RAM_DEPTH, 256, RAM size in DATA_W words (power of 2)
RAM_BASE, 32'h0000_0000, RAM region base address
IO_BASE, 32'h8000_0000, I/O region base address
NUM_IO, 4, number of output registers (1..32)
WAIT_CYCLES, 1, extra cycles before a RAM access completes (0..15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  1  CPU access request; held with all request fields stable until ready
we  input  1  1 = write, 0 = read
addr  input  32  byte address
wdata  input  DATA_W  write data
be  input  DATA_W/8  byte enables for writes (ignored on reads)
rdata  output  DATA_W  read data, valid while ready=1
ready  output  1  one-cycle completion pulse
err  output  1  access fault, qualified by ready
io_out  output  NUM_IO*DATA_W  output registers; reg i occupies [i*DATA_W +: DATA_W]
cyc_cnt  output  32  cycle counter value

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; ready=0, err=0, rdata=0, io_out=0, cyc_cnt=0, wait counter=0. RAM contents are not reset. Reset asserted mid-access aborts the access; any pending write is discarded.
- cyc_cnt increments every cycle when out of reset and wraps 0xFFFF_FFFF -> 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if req=1, latch we/addr/wdata/be and decode.
  - RAM hit with WAIT_CYCLES>0 -> WAIT, counter loaded with WAIT_CYCLES-1.
  - Any other case -> RESP.
- WAIT: decrement the counter; at 0 -> RESP.
- RESP: ready=1 for exactly one cycle, then -> IDLE unconditionally. This gives one mandatory idle bubble between accesses. req is ignored in RESP.
- Latency from req sampled in IDLE to ready: WAIT_CYCLES+1 cycles for RAM, 1 cycle for I/O and faults.
- Decode is evaluated on the latched address:
  - RAM hit: RAM_BASE <= addr < RAM_BASE + 4*RAM_DEPTH; word index = (addr-RAM_BASE)>>2.
  - IO reg i: addr == IO_BASE + 4*i, i < NUM_IO.
  - Counter: addr == IO_BASE + 32'h100, read-only.
  - Fault (err=1 with ready): misaligned address (addr[1:0]!=0), unmapped address, write to the counter, or I/O index >= NUM_IO.
- On a fault: rdata = 32'hDEAD_BEEF (low DATA_W bits); no state is modified.
- Writes commit on the clock edge that ends RESP.
  - RAM: only bytes with be[k]=1 are updated.
  - I/O: byte-enabled update of io_out reg i.
  - be=0 completes normally as a no-op.
- Reads: rdata holds the RAM word, I/O register, or cyc_cnt sampled at the entry into RESP. Outside RESP, rdata=0.
- Read-after-write to the same address returns the new data, because the write completes before the next request is accepted.
- err=0 whenever ready=0.

Test Plan:
- Reset then RAM write addr=0x10, wdata=0xCAFEF00D, be=4'hF; read 0x10 -> ready 2 cycles after req (WAIT_CYCLES=1), rdata=0xCAFEF00D, err=0.
- Byte-enable write: RAM 0x20 = 0x11223344, then write 0xAABBCCDD with be=4'b0101 -> read returns 0x11BB33DD.
- I/O: write 0x8000_0008 = 0x5A -> io_out[2*32 +: 32]=0x5A after the completing edge, other regs stay 0. Read 0x8000_000C -> 0, err=0. Write 0x8000_0010 with NUM_IO=4 -> err=1, rdata=0xDEADBEEF.
- Faults: read 0x0000_0402 (misaligned) -> err=1; read 0x0000_0400 (beyond 256 words) -> err=1; write 0x8000_0100 -> err=1; each completes in 1 cycle and leaves state unchanged.
- Counter: read 0x8000_0100 at cycle N after reset release -> rdata equals cyc_cnt at RESP entry. Force cyc_cnt near 0xFFFF_FFFF -> wraps to 0.
- Async reset during WAIT (WAIT_CYCLES=3, pending write 0x1234 to 0x40) -> ready never pulses, state IDLE immediately, io_out=0. A subsequent read of 0x40 shows the old RAM value.
